// File: rtl/pingpong_framebuffer.sv
// Double-buffered frame store: capture writes the back bank, scan-out reads the front bank.
// Optional frame re-display counter is built only when PINGPONG_FRAMEBUFFER_REPEAT_COUNT_EN is defined.
module pingpong_framebuffer #(
  parameter int IN_WIDTH   = 4,
  parameter int OUT_WIDTH  = 1,
  parameter int DEPTH_BITS = 12,
  parameter int OUT_REG    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 out_req,
  input  logic                 out_first,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 frame_pending,
  output logic                 overflow,
  output logic [7:0]           repeat_count
);

  localparam int R     = IN_WIDTH / OUT_WIDTH;
  localparam int LOG2R = $clog2(R);
  localparam int RA    = DEPTH_BITS + LOG2R;
  localparam int SUBW  = (LOG2R > 0) ? LOG2R : 1;
  localparam int WORDS = 2 ** DEPTH_BITS;

  logic [IN_WIDTH-1:0]   mem_q [2*WORDS];

  logic                  wr_bank_q, wr_bank_d;
  logic                  frame_pending_q, frame_pending_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [RA-1:0]         rd_ptr_q, rd_ptr_d;

  logic                  s1_vld_q;
  logic [IN_WIDTH-1:0]   s1_word_q;
  logic [SUBW-1:0]       s1_sub_q;
  logic [OUT_WIDTH-1:0]  s1_sel;

  logic                  wr_en;
  logic                  swap;
  logic                  rd_bank_eff;
  logic [RA-1:0]         rd_addr_eff;
  logic [DEPTH_BITS-1:0] rd_word;
  logic [SUBW-1:0]       rd_sub;

  // The front bank is always the one not being written, so a single bank bit suffices.
  always_comb begin
    wr_en       = in_valid && !frame_pending_q;
    swap        = out_first && frame_pending_q;
    rd_bank_eff = swap ? wr_bank_q : ~wr_bank_q;
    rd_addr_eff = out_first ? '0 : rd_ptr_q;
    rd_word     = DEPTH_BITS'(rd_addr_eff / RA'(R));
    rd_sub      = SUBW'(rd_addr_eff % RA'(R));
  end

  always_comb begin
    wr_bank_d       = wr_bank_q;
    frame_pending_d = frame_pending_q;
    wr_ptr_d        = wr_ptr_q;
    overflow_d      = overflow_q;
    rd_ptr_d        = rd_ptr_q;
    if (swap) begin
      wr_bank_d       = ~wr_bank_q;
      frame_pending_d = 1'b0;
    end
    // A write and a swap are mutually exclusive: writes need !frame_pending, swaps need it set.
    if (wr_en) begin
      if (in_last) begin
        wr_ptr_d        = '0;
        frame_pending_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        if (&wr_ptr_q) begin
          overflow_d = 1'b1;
        end
      end
    end
    if (out_req) begin
      rd_ptr_d = rd_addr_eff + RA'(1);
    end else if (out_first) begin
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q       <= 1'b0;
      frame_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      frame_pending_q <= frame_pending_d;
      overflow_q      <= overflow_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[{wr_bank_q, wr_ptr_q}] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_word_q <= '0;
      s1_sub_q  <= '0;
    end else begin
      s1_vld_q <= out_req;
      if (out_req) begin
        s1_word_q <= mem_q[{rd_bank_eff, rd_word}];
        s1_sub_q  <= rd_sub;
      end
    end
  end

  // Sub-word 0 lives in the least significant bits of the stored word.
  always_comb begin
    s1_sel = OUT_WIDTH'(s1_word_q >> (s1_sub_q * OUT_WIDTH));
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                 out_vld_q;
      logic [OUT_WIDTH-1:0] out_data_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          out_vld_q  <= 1'b0;
          out_data_q <= '0;
        end else begin
          out_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            out_data_q <= s1_sel;
          end
        end
      end
      assign out_valid = out_vld_q;
      assign out_data  = out_data_q;
    end else begin : g_no_out_reg
      assign out_valid = s1_vld_q;
      assign out_data  = s1_sel;
    end
  endgenerate

`ifdef PINGPONG_FRAMEBUFFER_REPEAT_COUNT_EN
  logic [7:0] repeat_q, repeat_d;

  always_comb begin
    repeat_d = repeat_q;
    if (out_first && !frame_pending_q && (repeat_q != 8'hFF)) begin
      repeat_d = repeat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_q <= 8'd0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign repeat_count = repeat_q;
`else
  assign repeat_count = 8'd0;
`endif

  assign in_ready      = !frame_pending_q;
  assign frame_pending = frame_pending_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_pingpong_framebuffer.sv
// Self-checking bench for pingpong_framebuffer (4-in/1-out, 16 words per bank, output register on).
// A frame-level reference model predicts every output cycle by cycle.
module tb_pingpong_framebuffer;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_last, out_req, out_first;
  logic [3:0] in_data;
  logic       in_ready, out_valid, frame_pending, overflow;
  logic [0:0] out_data;
  logic [7:0] repeat_count;

  always #5 clk = ~clk;

  pingpong_framebuffer #(
    .IN_WIDTH(4), .OUT_WIDTH(1), .DEPTH_BITS(4), .OUT_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_req(out_req), .out_first(out_first),
    .out_valid(out_valid), .out_data(out_data),
    .frame_pending(frame_pending), .overflow(overflow), .repeat_count(repeat_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: two frames of 16 nibbles, which one is being filled, and the read position.
  logic [3:0] m_mem [2][16];
  bit         m_known [2][16];
  bit         m_wrb, m_pend, m_ovf;
  int         m_wp, m_rp, m_rep;
  bit         s_v, s_d, s_known;
  bit         m_ov, m_od, m_od_known;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [3:0] d, input bit last,
                       input bit req, input bit first);
    bit sw;
    int rb, addr, w;
    reset = rst; in_valid = v; in_data = d; in_last = last; out_req = req; out_first = first;
    if (rst) begin
      m_wrb = 0; m_pend = 0; m_ovf = 0; m_wp = 0; m_rp = 0; m_rep = 0;
      s_v = 0; m_ov = 0; m_od = 0; m_od_known = 1;
    end else begin
      sw   = first && m_pend;
      rb   = sw ? int'(m_wrb) : int'(!m_wrb);
      addr = first ? 0 : m_rp;
      m_ov = s_v;
      if (s_v) begin
        m_od = s_d; m_od_known = s_known;
      end
      s_v = req;
      if (req) begin
        w = addr / 4;
        s_d = m_mem[rb][w][addr % 4];
        s_known = m_known[rb][w];
        m_rp = (addr + 1) % 64;
      end else if (first) begin
        m_rp = 0;
      end
      if (first && !m_pend && m_rep < 255) m_rep++;
      if (v && !m_pend) begin
        m_mem[m_wrb][m_wp] = d;
        m_known[m_wrb][m_wp] = 1;
        if (last) begin
          m_wp = 0; m_pend = 1;
        end else begin
          if (m_wp == 15) m_ovf = 1;
          m_wp = (m_wp + 1) % 16;
        end
      end else if (sw) begin
        m_wrb = !m_wrb; m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    chk("out_valid", 8'(out_valid), 8'(m_ov));
    if (m_od_known) chk("out_data", 8'(out_data), 8'(m_od));
    chk("in_ready", 8'(in_ready), 8'(!m_pend));
    chk("frame_pending", 8'(frame_pending), 8'(m_pend));
    chk("overflow", 8'(overflow), 8'(m_ovf));
`ifdef PINGPONG_FRAMEBUFFER_REPEAT_COUNT_EN
    chk("repeat_count", repeat_count, 8'(m_rep));
`else
    chk("repeat_count", repeat_count, 8'd0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic write_frame(input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      cycle(0, 1, 4'($urandom), with_last && (i == n - 1), 0, 0);
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 0, 1, i == 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) m_known[b][i] = 0;
    reset = 1; in_valid = 0; in_data = 0; in_last = 0; out_req = 0; out_first = 0;
    @(posedge clk);
    cycle(1, 0, 4'h0, 0, 0, 0);
    cycle(1, 0, 4'h0, 0, 0, 0);

    // Frame of 0x1..0xF,0x0 then full scan-out
    for (int i = 0; i < 16; i++) cycle(0, 1, 4'((i + 1) % 16), i == 15, 0, 0);
    idle(1);
    scan(64);
    idle(3);

    // New frame shown once, then re-displayed
    write_frame(16, 1);
    scan(64);
    idle(3);
    scan(64);
    idle(3);

    // Writes held off while a frame waits
    write_frame(16, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 4'($urandom), i == 2, 0, 0);
    scan(64);
    idle(3);

    // Seventeen words without in_last, then close the frame
    write_frame(17, 0);
    idle(2);
    cycle(0, 1, 4'($urandom), 1, 0, 0);
    scan(64);
    idle(3);

    // in_last coinciding with out_first
    write_frame(15, 0);
    cycle(0, 1, 4'($urandom), 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0, 0, 1, 0);
    scan(64);
    idle(3);

    // Reset in the middle of a read burst
    write_frame(16, 1);
    scan(7);
    cycle(1, 0, 4'h0, 0, 1, 0);
    idle(1);
    scan(64);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(0, ($urandom % 4) != 0, 4'($urandom), ($urandom % 20) == 0,
            ($urandom % 2) == 1, ($urandom % 25) == 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pingpong_framebuffer.md
Name: pingpong_framebuffer

Overview:
- Parametrised double-buffered frame store for the STN-to-HDMI path.
- The STN capture side writes IN_WIDTH-bit words into the back bank. The HDMI scan-out side reads OUT_WIDTH-bit sub-words from the front bank.
- Banks swap only at a scan-out frame start, and only when a complete frame is waiting.
- Replaces fixed 4-in/1-out block RAM instances. Memory is inferred, with a registered read and an optional output register.

Parameters:
- IN_WIDTH, 4: write word width in bits. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 1: read word width in bits.
- DEPTH_BITS, 12: log2 of write words per bank. Each bank holds 2^DEPTH_BITS x IN_WIDTH bits.
- OUT_REG, 1: 1 adds an extra output register stage; 0 omits it.

Ports:
- clk  in  1  single clock for both sides.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  write strobe. A write occurs when in_valid && in_ready.
- in_data  in  IN_WIDTH  pixel word.
- in_last  in  1  marks the final word of a frame; qualified by the write.
- in_ready  out  1  low while a completed frame awaits swap.
- out_req  in  1  read strobe.
- out_first  in  1  scan-out frame start: swap point and read-pointer reset.
- out_valid  out  1  out_data valid.
- out_data  out  OUT_WIDTH  read sub-word.
- frame_pending  out  1  back bank holds a complete, unswapped frame.
- overflow  out  1  sticky: write pointer wrapped without in_last.
- repeat_count  out  8  frames re-displayed (see Optional Feature).

Behaviour:
- Definitions:
  - R = IN_WIDTH/OUT_WIDTH.
  - Read address width = DEPTH_BITS + log2(R).
  - Sub-word k of write word j sits at read address j*R+k and holds in_data[k*OUT_WIDTH +: OUT_WIDTH]; k=0 is read first.
- Reset values:
  - wr_bank=0, rd_bank=1, wr_ptr=0, rd_ptr=0.
  - frame_pending=0, in_ready=1, overflow=0, repeat_count=0.
  - out_valid=0, out_data=0, and all pipeline valids 0.
  - Memory contents are not cleared.
- Write path:
  - Each accepted write stores to [wr_bank][wr_ptr]; wr_ptr increments and wraps at 2^DEPTH_BITS.
  - Accepted write with in_last: wr_ptr<=0 and frame_pending<=1 next cycle. in_ready = !frame_pending, so it drops the cycle after the in_last write.
  - Accepted write without in_last at wr_ptr=max: wr_ptr wraps to 0 and overflow<=1 (sticky until reset).
  - in_valid while in_ready=0: ignored, no state change.
- Swap, evaluated on the registered frame_pending:
  - out_first && frame_pending: wr_bank<=rd_bank, rd_bank<=wr_bank, frame_pending<=0; in_ready returns high the next cycle.
  - out_first && !frame_pending: no swap; the front bank is re-displayed.
  - out_first in the same cycle as an in_last write: no swap that cycle; frame_pending sets and the swap happens at the next out_first.
- Read path:
  - Effective bank = post-swap rd_bank, computed combinationally in the out_first cycle.
  - Effective address = out_first ? 0 : rd_ptr.
  - out_req reads at the effective bank and address; rd_ptr <= effective address + 1, wrapping silently.
  - out_first without out_req: rd_ptr<=0, no read.
- Latency: out_req at cycle t gives out_valid=1 and out_data at t+1+OUT_REG. Fully pipelined, one read per cycle.
- out_data holds its last value while out_valid=0.
- Reset asserted mid-operation: all registers return to their reset values the next cycle; in-flight reads are discarded.

Optional Feature:
- Macro: PINGPONG_FRAMEBUFFER_REPEAT_COUNT_EN.
- Defined: repeat_count increments on each out_first && !frame_pending and saturates at 255; cleared by reset.
- Undefined: repeat_count is tied to 0 and no counter logic is built.

Test Plan:
All scenarios use IN_WIDTH=4, OUT_WIDTH=1, DEPTH_BITS=4, OUT_REG=1.
1. Reset, then write 0x1..0xF,0x0 with in_last on the 16th word, then out_first + 16 out_req.
   -> frame_pending=1 and in_ready=0 after the in_last write. Swap occurs on out_first. Data valid 2 cycles after each out_req; the word 0x1 reads back as bits 1,0,0,0.
2. After scenario 1, write frame B, then out_first, out_first with no new frame.
   -> First out_first shows B. Second out_first shows B again and repeat_count=1 with the macro (0 without).
3. in_valid held while in_ready=0.
   -> No memory change and wr_ptr unchanged; a readback after the swap shows the original frame.
4. Write 17 words with no in_last.
   -> overflow=1 after the 16th write; word 17 overwrites address 0; overflow stays 1 until reset.
5. in_last write and out_first in the same cycle.
   -> No swap; frame_pending=1. The next out_first swaps and reads the new frame from address 0.
6. Assert reset mid-read burst.
   -> out_valid=0 the next cycle and all outputs at reset values; the next out_first with no pending frame re-reads bank 1 from address 0.
